f_wb_arbiter: RTL

- Write-back arbiter for the floating-point register file.
- Shares the register file's WRITE_PORTS write ports among NUM_REQ result producers: FP add/sub, FP mul, FP div/sqrt and load unit.
- Uses round-robin priority with a valid/ready handshake per requester.
- Drives registered write enable, address and data straight into the FP register file write ports.

---
 rtl/f_wb_arbiter_pkg.sv | 39 +++
 rtl/f_wb_arbiter_rr_picker.sv | 44 ++++
 rtl/f_wb_arbiter.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/f_wb_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// f_wb_arbiter_pkg
// Shared types and constants for the FP register file write-back arbiter.
//   FWB_NUM_REQ     : number of result producers sharing the write ports
//   FWB_WRITE_PORTS : number of FP register file write ports
//   f_register_e    : FP architectural register name (f0..f31)
//   float_t         : single-precision raw bit pattern
//   fwb_req_t       : one requester's pending write (valid, register, data)
//   fwb_src_e       : requester index of each producing unit
// ----------------------------------------------------------------------------
package f_wb_arbiter_pkg;

    localparam int FWB_NUM_REQ     = 4;
    localparam int FWB_WRITE_PORTS = 2;

    typedef enum logic [4:0] {
        F0,  F1,  F2,  F3,  F4,  F5,  F6,  F7,
        F8,  F9,  F10, F11, F12, F13, F14, F15,
        F16, F17, F18, F19, F20, F21, F22, F23,
        F24, F25, F26, F27, F28, F29, F30, F31
    } f_register_e;

    typedef logic [31:0] float_t;

    typedef struct packed {
        logic        valid;
        f_register_e faddr;
        float_t      fdata;
    } fwb_req_t;

    // Requester index of each unit; this is also the round-robin order.
    typedef enum logic [1:0] {
        FWB_ADD     = 2'd0,
        FWB_MUL     = 2'd1,
        FWB_DIVSQRT = 2'd2,
        FWB_LOAD    = 2'd3
    } fwb_src_e;

endpackage

// File: rtl/f_wb_arbiter_rr_picker.sv
// ----------------------------------------------------------------------------
// f_wb_arbiter_rr_picker
// Circular first-set-bit picker. Scans positions start_ptr, start_ptr+1, ...
// (wrapping at N-1 back to 0) and returns the first position where both
// valid and mask are set, as a one-hot vector.
//   valid     : candidate requests
//   mask      : positions still allowed to win (1 = eligible)
//   start_ptr : position the scan begins at
//   grant_oh  : one-hot winner, all zero when nothing qualifies
//   found     : a winner exists
// ----------------------------------------------------------------------------
module f_wb_arbiter_rr_picker #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  valid,
    input  logic [N-1:0]  mask,
    input  logic [PW-1:0] start_ptr,
    output logic [N-1:0]  grant_oh,
    output logic          found
);

    localparam logic [PW:0] N_W = (PW + 1)'(N);

    always_comb begin
        logic [PW:0] pos;
        grant_oh = '0;
        found    = 1'b0;
        pos      = '0;
        for (int i = 0; i < N; i++) begin
            // One extra bit of headroom so start_ptr + i cannot overflow
            // before the wrap correction.
            pos = {1'b0, start_ptr} + (PW + 1)'(i);
            if (pos >= N_W) begin
                pos = pos - N_W;
            end
            if (!found && valid[pos[PW-1:0]] && mask[pos[PW-1:0]]) begin
                grant_oh[pos[PW-1:0]] = 1'b1;
                found                 = 1'b1;
            end
        end
    end

endmodule

// File: rtl/f_wb_arbiter.sv
// ----------------------------------------------------------------------------
// f_wb_arbiter
// Write-back arbiter for the FP register file. NUM_REQ result producers
// (add/sub, mul, div/sqrt, load) compete for WRITE_PORTS register file write
// ports using round-robin priority. The write ports are registered and feed
// the register file directly.
//
// Handshake: a requester holds valid, faddr and fdata stable until it sees
// ready; the transfer happens in the cycle where valid and ready are both
// high, and ready is never raised without valid.
//
// Ports:
//   clk_i        clock
//   rst_i        asynchronous reset, active-high
//   clk_en_i     clock enable; low freezes all state and grants nothing
//   req_valid_i  per-requester pending result
//   req_faddr_i  per-requester destination FP register
//   req_fdata_i  per-requester result data
//   req_ready_o  per-requester grant (combinational, same cycle)
//   we_o         registered register file write enables
//   wr_faddr_o   registered register file write addresses
//   wr_fdata_o   registered register file write data
//   stall_cnt_o  saturating count of cycles with an ungranted valid request
//                (only when MGT_01_FWB_STALL_CNT_EN is defined)
//
// Build option: MGT_01_FWB_STALL_CNT_EN adds stall_cnt_o and its counter;
// arbitration is identical either way.
// ----------------------------------------------------------------------------
module f_wb_arbiter
    import f_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = FWB_NUM_REQ,
    parameter int WRITE_PORTS = FWB_WRITE_PORTS
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              clk_en_i,
    input  logic [NUM_REQ-1:0]                req_valid_i,
    input  logic [NUM_REQ-1:0][4:0]           req_faddr_i,
    input  float_t [NUM_REQ-1:0]              req_fdata_i,
    output logic [NUM_REQ-1:0]                req_ready_o,
    output logic [WRITE_PORTS-1:0]            we_o,
    output logic [WRITE_PORTS-1:0][4:0]       wr_faddr_o,
    output float_t [WRITE_PORTS-1:0]          wr_fdata_o
`ifdef MGT_01_FWB_STALL_CNT_EN
    ,
    output logic [31:0]                       stall_cnt_o
`endif
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0]                         rr_ptr;
    logic [NUM_REQ-1:0]                    eligible;
    logic [WRITE_PORTS-1:0][NUM_REQ-1:0]   port_gnt;
    logic [WRITE_PORTS-1:0]                port_found;
    logic [WRITE_PORTS-1:0][4:0]           port_addr;
    float_t [WRITE_PORTS-1:0]              port_data;
    logic                                  any_gnt;
    logic [PW-1:0]                         last_idx;
    logic [PW-1:0]                         next_ptr;

    // Nothing may be granted while frozen or held in reset.
    assign eligible = req_valid_i & {NUM_REQ{clk_en_i & ~rst_i}};

    // ------------------------------------------------------------------
    // One picker per write port. Each port's mask removes requesters that
    // an earlier port already took, plus every requester aiming at the
    // register an earlier port is writing this cycle. All pickers start at
    // rr_ptr; because earlier winners are masked out, port p effectively
    // continues the circular scan where port p-1 stopped.
    // ------------------------------------------------------------------
    for (genvar p = 0; p < WRITE_PORTS; p++) begin : g_port
        logic [NUM_REQ-1:0] mask_in;
        logic [NUM_REQ-1:0] mask_out;
        logic [NUM_REQ-1:0] gnt;
        logic               found;
        logic [4:0]         addr;
        float_t             data;

        if (p == 0) begin : g_head
            assign mask_in = '1;
        end else begin : g_tail
            assign mask_in = g_port[p-1].mask_out;
        end

        f_wb_arbiter_rr_picker #(
            .N  (NUM_REQ),
            .PW (PW)
        ) u_picker (
            .valid     (eligible),
            .mask      (mask_in),
            .start_ptr (rr_ptr),
            .grant_oh  (gnt),
            .found     (found)
        );

        // One-hot select of the winner's address and data (zero if none).
        always_comb begin
            addr = '0;
            data = '0;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (gnt[k]) begin
                    addr = addr | req_faddr_i[k];
                    data = data | req_fdata_i[k];
                end
            end
        end

        always_comb begin
            mask_out = '0;
            for (int k = 0; k < NUM_REQ; k++) begin
                mask_out[k] = mask_in[k] & ~gnt[k]
                            & ~(found && (req_faddr_i[k] == addr));
            end
        end

        assign port_gnt[p]   = gnt;
        assign port_found[p] = found;
        assign port_addr[p]  = addr;
        assign port_data[p]  = data;
    end

    always_comb begin
        req_ready_o = '0;
        for (int p = 0; p < WRITE_PORTS; p++) begin
            req_ready_o = req_ready_o | port_gnt[p];
        end
    end

    // The highest-numbered port that won holds the requester furthest along
    // the scan; the pointer moves to the position just after it.
    always_comb begin
        any_gnt  = 1'b0;
        last_idx = '0;
        for (int p = 0; p < WRITE_PORTS; p++) begin
            if (port_found[p]) begin
                any_gnt = 1'b1;
                for (int k = 0; k < NUM_REQ; k++) begin
                    if (port_gnt[p][k]) begin
                        last_idx = PW'(k);
                    end
                end
            end
        end
        if (last_idx == PW'(NUM_REQ - 1)) begin
            next_ptr = '0;
        end else begin
            next_ptr = last_idx + PW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Registered write ports and round-robin pointer. While clk_en_i is low
    // everything holds; the register file is gated by the same enable, so a
    // held we_o does not write twice.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            we_o       <= '0;
            wr_faddr_o <= '0;
            wr_fdata_o <= '0;
            rr_ptr     <= '0;
        end else if (clk_en_i) begin
            for (int p = 0; p < WRITE_PORTS; p++) begin
                we_o[p]       <= port_found[p];
                wr_faddr_o[p] <= port_addr[p];
                wr_fdata_o[p] <= port_data[p];
            end
            if (any_gnt) begin
                rr_ptr <= next_ptr;
            end
        end
    end

`ifdef MGT_01_FWB_STALL_CNT_EN
    // Counts enabled cycles in which some valid requester was left waiting,
    // whether from port shortage or a same-register conflict. Saturates.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
        end else if (clk_en_i && (|(req_valid_i & ~req_ready_o))
                     && (stall_cnt_o != 32'hFFFF_FFFF)) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`else
    // Stall counter not built in this configuration.
`endif

endmodule
